// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer.
package nibble_serial_adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_cla.sv
// 4-bit carry-lookahead slice exposing block generate/propagate.
module cla_4_bit_augmented (
    output logic [3:0] s,
    output logic       BP,
    output logic       BG,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        s    = p ^ c;
        BP   = &p;
        BG   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Add/subtract WIDTH-bit operands one nibble per clock through a single CLA slice.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NNIB = WIDTH / NIBBLE_W;
    localparam int IW   = $clog2(NNIB);
    localparam logic [IW-1:0] LAST = IW'(NNIB - 1);

    state_t state;
    logic [IW-1:0] idx;
    logic [IW-1:0] nidx;
    logic          carry;
    logic [NNIB-1:0][NIBBLE_W-1:0] a_r;
    logic [NNIB-1:0][NIBBLE_W-1:0] b_r;
    logic [NNIB-1:0][NIBBLE_W-1:0] sum_r;
    logic [NIBBLE_W-1:0] na;
    logic [NIBBLE_W-1:0] nb;
    logic [NIBBLE_W-1:0] slice_s;
    logic          slice_bp;
    logic          slice_bg;
    logic          c_next;

    cla_4_bit_augmented u_cla (
        .s   (slice_s),
        .BP  (slice_bp),
        .BG  (slice_bg),
        .a   (na),
        .b   (nb),
        .cin (carry)
    );

    always_comb begin
        c_next = slice_bg | (slice_bp & carry);
        nidx   = (idx == LAST) ? '0 : idx + IW'(1);
    end

    assign sum = sum_r;

    // The slice operands are registered: nibble 0 is loaded straight from the
    // inputs on acceptance, each later nibble is fetched while the current one
    // is being committed, so RUN lasts exactly NNIB cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum_r <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            na    <= '0;
            nb    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        na    <= a[NIBBLE_W-1:0];
                        nb    <= sub ? ~b[NIBBLE_W-1:0] : b[NIBBLE_W-1:0];
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                        sum_r <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_r[idx] <= slice_s;
                    carry      <= c_next;
                    if (idx == LAST) begin
                        cout  <= c_next;
                        ovf   <= (a_r[NNIB-1][NIBBLE_W-1] ^ b_r[NNIB-1][NIBBLE_W-1]
                                  ^ slice_s[NIBBLE_W-1]) ^ c_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx <= nidx;
                        na  <= a_r[nidx];
                        nb  <= b_r[nidx];
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for 16- and 32-bit nibble-serial adder instances.
module tb_nibble_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start16 = 1'b0, sub16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    logic        start32 = 1'b0, sub32 = 1'b0, cin32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, cout32, ovf32;
    logic [31:0] sum32;

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .cin(cin16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    nibble_serial_adder_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .sub(sub32), .a(a32), .b(b32),
        .cin(cin32), .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .ovf(ovf32)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Expected entries are {ovf, cout, sum[31:0]}.
    logic [33:0] q16[$];
    logic [33:0] q32[$];
    logic prev_done16 = 1'b0;
    logic prev_done32 = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [33:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                          input logic sv, input logic cv);
        logic [31:0] mask, bb, s;
        logic [32:0] full;
        logic        co, sa, sb, ss;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        bb   = (sv ? ~bv : bv) & mask;
        full = {1'b0, av & mask} + {1'b0, bb} + {32'd0, sv ? 1'b1 : cv};
        s    = full[31:0] & mask;
        co   = full[w];
        sa   = av[w-1];
        sb   = bb[w-1];
        ss   = s[w-1];
        return {(sa == sb) && (ss != sa), co, s};
    endfunction

    always @(negedge clk) begin
        if (done16) begin
            chk("done16_width", {63'd0, prev_done16}, 64'd0);
            if (q16.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done16_unexpected: actual=done required=no done (sum=%0h)", sum16);
            end else begin
                logic [33:0] e;
                e = q16.pop_front();
                chk("sum16", {48'd0, sum16}, {48'd0, e[15:0]});
                chk("cout16", {63'd0, cout16}, {63'd0, e[32]});
                chk("ovf16", {63'd0, ovf16}, {63'd0, e[33]});
            end
        end
        prev_done16 = done16;
    end

    always @(negedge clk) begin
        if (done32) begin
            chk("done32_width", {63'd0, prev_done32}, 64'd0);
            if (q32.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done32_unexpected: actual=done required=no done (sum=%0h)", sum32);
            end else begin
                logic [33:0] e;
                e = q32.pop_front();
                chk("sum32", {32'd0, sum32}, {32'd0, e[31:0]});
                chk("cout32", {63'd0, cout32}, {63'd0, e[32]});
                chk("ovf32", {63'd0, ovf32}, {63'd0, e[33]});
            end
        end
        prev_done32 = done32;
    end

    // Issue one operation, then wait (bounded) for done and check latency and busy length.
    task automatic do_op(input bit w32, input logic [31:0] av, input logic [31:0] bv,
                         input logic sv, input logic cv, input logic [33:0] exp);
        int lat = 0;
        int busy_n = 0;
        int nnib;
        nnib = w32 ? 8 : 4;
        @(negedge clk);
        if (w32) begin
            a32 = av; b32 = bv; sub32 = sv; cin32 = cv; start32 = 1'b1;
            q32.push_back(exp);
        end else begin
            a16 = av[15:0]; b16 = bv[15:0]; sub16 = sv; cin16 = cv; start16 = 1'b1;
            q16.push_back(exp);
        end
        @(posedge clk);
        #1;
        start16 = 1'b0;
        start32 = 1'b0;
        a16 = ~a16; b16 = ~b16; sub16 = ~sub16; cin16 = ~cin16;
        a32 = ~a32; b32 = ~b32; sub32 = ~sub32; cin32 = ~cin32;
        for (int t = 1; t <= 40 && lat == 0; t++) begin
            @(negedge clk);
            if (w32 ? busy32 : busy16) busy_n++;
            if (w32 ? done32 : done16) lat = t;
        end
        chk(w32 ? "latency32" : "latency16", 64'(lat), 64'(nnib + 1));
        chk(w32 ? "busy32_cycles" : "busy16_cycles", 64'(busy_n), 64'(nnib));
    endtask

    initial begin
        int done_at[$];

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy16", {63'd0, busy16}, 64'd0);
        chk("rst_done16", {63'd0, done16}, 64'd0);
        chk("rst_sum16", {48'd0, sum16}, 64'd0);
        chk("rst_cout16", {63'd0, cout16}, 64'd0);
        chk("rst_ovf16", {63'd0, ovf16}, 64'd0);
        chk("rst_busy32", {63'd0, busy32}, 64'd0);
        chk("rst_sum32", {32'd0, sum32}, 64'd0);
        rst_n = 1'b1;

        // Directed vectors with hand-computed results.
        do_op(1'b0, 32'h1234, 32'h0FCD, 1'b0, 1'b0, {1'b0, 1'b0, 32'h2201});
        do_op(1'b0, 32'h8000, 32'h0001, 1'b1, 1'b0, {1'b1, 1'b1, 32'h7FFF});
        do_op(1'b0, 32'h0003, 32'h0005, 1'b1, 1'b0, {1'b0, 1'b0, 32'hFFFE});
        do_op(1'b0, 32'h0003, 32'h0005, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFE});

        // start held high; operands change every cycle, only k=0,6,12 are accepted.
        q16.push_back({1'b0, 1'b0, 32'h0101});
        q16.push_back({1'b0, 1'b0, 32'h6767});
        q16.push_back({1'b0, 1'b0, 32'hCDCD});
        for (int k = 0; k <= 18; k++) begin
            @(negedge clk);
            if (done16) done_at.push_back(k);
            a16 = 16'(k * 16'h1111);
            b16 = 16'h0101;
            sub16 = 1'b0;
            cin16 = 1'b0;
            start16 = (k <= 12);
        end
        start16 = 1'b0;
        chk("hold_done_count", 64'(done_at.size()), 64'd3);
        if (done_at.size() == 3) begin
            chk("hold_done0", 64'(done_at[0]), 64'd5);
            chk("hold_done1", 64'(done_at[1]), 64'd11);
            chk("hold_done2", 64'(done_at[2]), 64'd17);
        end
        chk("hold_drained", 64'(q16.size()), 64'd0);

        do_op(1'b0, 32'hFFFF, 32'h0000, 1'b0, 1'b1, {1'b0, 1'b1, 32'h0000});

        // Reset while RUN is at idx=2; the operation must vanish without a done.
        @(negedge clk);
        a16 = 16'h1111; b16 = 16'h2222; sub16 = 1'b0; cin16 = 1'b0; start16 = 1'b1;
        @(posedge clk);
        #1 start16 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {63'd0, busy16}, 64'd0);
        chk("midrst_done", {63'd0, done16}, 64'd0);
        chk("midrst_sum", {48'd0, sum16}, 64'd0);
        chk("midrst_cout", {63'd0, cout16}, 64'd0);
        repeat (8) @(negedge clk);
        do_op(1'b0, 32'h0001, 32'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 32'h0002});

        // 32-bit directed sanity vectors.
        do_op(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
        do_op(1'b1, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, {1'b0, 1'b0, 32'hFFFF_FFFF});

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra, rb;
            logic rs, rc;
            ra = {16'd0, 16'($urandom)};
            rb = {16'd0, 16'($urandom)};
            rs = 1'($urandom);
            rc = 1'($urandom);
            do_op(1'b0, ra, rb, rs, rc, model(16, ra, rb, rs, rc));
        end
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra, rb;
            logic rs, rc;
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            rc = 1'($urandom);
            do_op(1'b1, ra, rb, rs, rc, model(32, ra, rb, rs, rc));
        end

        repeat (4) @(negedge clk);
        chk("q16_empty", 64'(q16.size()), 64'd0);
        chk("q32_empty", 64'(q32.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
